// File: rtl/branch_pkg.sv
// Shared types and constants for the branch condition unit: condition
// codes, flag bit positions inside the {N,Z,C,V} nibble, and FSM states.
package branch_pkg;

  typedef enum logic [2:0] {
    EQ  = 3'd0,
    NE  = 3'd1,
    LT  = 3'd2,
    GE  = 3'd3,
    LTU = 3'd4,
    GEU = 3'd5,
    AL  = 3'd6,
    NV  = 3'd7
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/branch_condition_unit_cond_eval.sv
// Combinational condition evaluator: decides taken/not-taken from a
// {N,Z,C,V} flag nibble and a 3-bit condition code.
module cond_eval
  import branch_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [2:0] cond,
  output logic       taken
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Map each condition code onto its flag expression
  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      EQ:      taken = z;
      NE:      taken = ~z;
      LT:      taken = n ^ v;
      GE:      taken = ~(n ^ v);
      LTU:     taken = ~c;
      GEU:     taken = c;
      AL:      taken = 1'b1;
      NV:      taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_condition_unit.sv
// Branch condition unit: holds the ALU flag register, accepts branch
// requests from decode, waits for in-flight flag writes when needed, and
// hands the resolved direction and target to fetch. Keeps saturating
// counts of delivered taken/not-taken resolutions.
module branch_condition_unit
  import branch_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flag_we,
  input  logic [3:0]        flags_in,
  input  logic              flag_pending,
  input  logic              flush,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_cond,
  input  logic [ADDR_W-1:0] br_target,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_taken,
  output logic [ADDR_W-1:0] res_target,
  output logic [3:0]        flags_q,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  not_taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state;
  state_e            next_state;
  logic [2:0]        cond_q;
  logic [ADDR_W-1:0] target_q;
  logic              taken_q;
  logic [3:0]        eff_flags;
  logic [2:0]        eval_cond;
  logic              eval_taken;
  logic              capture;
  logic              load_result;
  logic              deliver;

  // A flag write in the same cycle is forwarded ahead of the register;
  // in IDLE the live request is evaluated, otherwise the captured one
  assign eff_flags = flag_we ? flags_in : flags_q;
  assign eval_cond = (state == IDLE) ? br_cond : cond_q;

  cond_eval u_cond_eval (
    .flags (eff_flags),
    .cond  (eval_cond),
    .taken (eval_taken)
  );

  assign br_ready   = (state == IDLE);
  assign res_valid  = (state == RESP);
  assign res_taken  = taken_q;
  assign res_target = target_q;

  // Next-state logic; flush overrides everything and suppresses side effects
  always_comb begin
    next_state  = state;
    capture     = 1'b0;
    load_result = 1'b0;
    deliver     = 1'b0;
    case (state)
      IDLE: begin
        if (br_valid) begin
          capture = 1'b1;
          if (flag_pending && !flag_we) begin
            next_state = WAIT;
          end else begin
            load_result = 1'b1;
            next_state  = RESP;
          end
        end
      end
      WAIT: begin
        if (flag_we) begin
          load_result = 1'b1;
          next_state  = RESP;
        end
      end
      RESP: begin
        if (res_ready) begin
          deliver    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (flush) begin
      next_state  = IDLE;
      capture     = 1'b0;
      load_result = 1'b0;
      deliver     = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Flag register loads on every write, independent of the FSM and flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (flag_we) begin
      flags_q <= flags_in;
    end
  end

  // Captured request and registered resolution, held stable through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_q   <= 3'd0;
      target_q <= '0;
      taken_q  <= 1'b0;
    end else begin
      if (capture) begin
        cond_q   <= br_cond;
        target_q <= br_target;
      end
      if (load_result) begin
        taken_q <= eval_taken;
      end
    end
  end

  // Saturating statistics, stepped only on a delivered resolution
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt     <= '0;
      not_taken_cnt <= '0;
    end else if (deliver) begin
      if (taken_q) begin
        if (!(&taken_cnt)) taken_cnt <= taken_cnt + CNT_ONE;
      end else begin
        if (!(&not_taken_cnt)) not_taken_cnt <= not_taken_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_branch_condition_unit.sv
// Directed bench for branch_condition_unit: a table of per-cycle vectors
// for the basic condition codes and forwarding, then hand-written
// sequences for pending flags, backpressure, flush, reset and saturation.
module tb_branch_condition_unit;

  logic       clk;
  logic       rst_n;
  logic       flag_we;
  logic [3:0] flags_in;
  logic       flag_pending;
  logic       flush;
  logic       br_valid;
  logic       br_ready;
  logic [2:0] br_cond;
  logic [7:0] br_target;
  logic       res_valid;
  logic       res_ready;
  logic       res_taken;
  logic [7:0] res_target;
  logic [3:0] flags_q;
  logic [15:0] taken_cnt;
  logic [15:0] not_taken_cnt;

  logic       s_br_ready;
  logic       s_res_valid;
  logic       s_res_taken;
  logic [7:0] s_res_target;
  logic [3:0] s_flags_q;
  logic [3:0] s_taken_cnt;
  logic [3:0] s_not_taken_cnt;

  int checks;
  int failures;

  branch_condition_unit #(.ADDR_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flags_in(flags_in),
    .flag_pending(flag_pending), .flush(flush), .br_valid(br_valid),
    .br_ready(br_ready), .br_cond(br_cond), .br_target(br_target),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .res_target(res_target), .flags_q(flags_q), .taken_cnt(taken_cnt),
    .not_taken_cnt(not_taken_cnt)
  );

  branch_condition_unit #(.ADDR_W(8), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flags_in(flags_in),
    .flag_pending(flag_pending), .flush(flush), .br_valid(br_valid),
    .br_ready(s_br_ready), .br_cond(br_cond), .br_target(br_target),
    .res_valid(s_res_valid), .res_ready(res_ready), .res_taken(s_res_taken),
    .res_target(s_res_target), .flags_q(s_flags_q), .taken_cnt(s_taken_cnt),
    .not_taken_cnt(s_not_taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [3:0] fin;
    logic       pend;
    logic       fl;
    logic       bv;
    logic [2:0] cond;
    logic [7:0] tgt;
    logic       rr;
    logic       e_ready;
    logic       e_valid;
    logic       e_taken;
    logic [7:0] e_target;
    logic [3:0] e_flags;
    logic [15:0] e_tcnt;
    logic [15:0] e_ncnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [3:0] fin,
                              input logic bv, input logic [2:0] cond,
                              input logic [7:0] tgt, input logic rr,
                              input logic e_ready, input logic e_valid,
                              input logic e_taken, input logic [7:0] e_target,
                              input logic [3:0] e_flags,
                              input logic [15:0] e_tcnt, input logic [15:0] e_ncnt);
    vec_t v;
    v.we = we; v.fin = fin; v.pend = 1'b0; v.fl = 1'b0;
    v.bv = bv; v.cond = cond; v.tgt = tgt; v.rr = rr;
    v.e_ready = e_ready; v.e_valid = e_valid; v.e_taken = e_taken;
    v.e_target = e_target; v.e_flags = e_flags;
    v.e_tcnt = e_tcnt; v.e_ncnt = e_ncnt;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [3:0] fin,
                               input logic pend, input logic fl,
                               input logic bv, input logic [2:0] cond,
                               input logic [7:0] tgt, input logic rr);
    flag_we = we; flags_in = fin; flag_pending = pend; flush = fl;
    br_valid = bv; br_cond = cond; br_target = tgt; res_ready = rr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
  endtask

  task automatic checkCore(input string tag, input logic e_ready, input logic e_valid,
                           input logic [3:0] e_flags, input logic [15:0] e_t,
                           input logic [15:0] e_n);
    checkOutput({tag, ".br_ready"}, 32'(br_ready), 32'(e_ready));
    checkOutput({tag, ".res_valid"}, 32'(res_valid), 32'(e_valid));
    checkOutput({tag, ".flags_q"}, 32'(flags_q), 32'(e_flags));
    checkOutput({tag, ".taken_cnt"}, 32'(taken_cnt), 32'(e_t));
    checkOutput({tag, ".not_taken_cnt"}, 32'(not_taken_cnt), 32'(e_n));
  endtask

  task automatic checkRes(input string tag, input logic e_taken, input logic [7:0] e_tgt);
    checkOutput({tag, ".res_taken"}, 32'(res_taken), 32'(e_taken));
    checkOutput({tag, ".res_target"}, 32'(res_target), 32'(e_tgt));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    idleInputs();

    // we fin bv cond tgt rr | rdy val tk tgt flags tcnt ncnt
    vecs.push_back(mk(1, 4'b0100, 0, 3'd0, 8'h00, 0, 1, 0, 0, 8'h00, 4'b0100, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 3'd0, 8'h3C, 0, 0, 1, 1, 8'h3C, 4'b0100, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 3'd0, 8'h00, 1, 1, 0, 0, 8'h00, 4'b0100, 1, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 3'd0, 8'h00, 0, 1, 0, 0, 8'h00, 4'b0000, 1, 0));
    vecs.push_back(mk(1, 4'b0100, 1, 3'd1, 8'h11, 0, 0, 1, 0, 8'h11, 4'b0100, 1, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 3'd0, 8'h00, 1, 1, 0, 0, 8'h00, 4'b0100, 1, 1));
    vecs.push_back(mk(1, 4'b1001, 0, 3'd0, 8'h00, 0, 1, 0, 0, 8'h00, 4'b1001, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 1, 3'd2, 8'h20, 0, 0, 1, 0, 8'h20, 4'b1001, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 3'd0, 8'h00, 1, 1, 0, 0, 8'h00, 4'b1001, 1, 2));
    vecs.push_back(mk(0, 4'b0000, 1, 3'd3, 8'h21, 0, 0, 1, 1, 8'h21, 4'b1001, 1, 2));
    vecs.push_back(mk(0, 4'b0000, 0, 3'd0, 8'h00, 1, 1, 0, 0, 8'h00, 4'b1001, 2, 2));
    vecs.push_back(mk(0, 4'b0000, 1, 3'd4, 8'h22, 0, 0, 1, 1, 8'h22, 4'b1001, 2, 2));
    vecs.push_back(mk(0, 4'b0000, 0, 3'd0, 8'h00, 1, 1, 0, 0, 8'h00, 4'b1001, 3, 2));
    vecs.push_back(mk(0, 4'b0000, 1, 3'd5, 8'h23, 0, 0, 1, 0, 8'h23, 4'b1001, 3, 2));
    vecs.push_back(mk(0, 4'b0000, 0, 3'd0, 8'h00, 1, 1, 0, 0, 8'h00, 4'b1001, 3, 3));
    vecs.push_back(mk(0, 4'b0000, 1, 3'd7, 8'h24, 0, 0, 1, 0, 8'h24, 4'b1001, 3, 3));
    vecs.push_back(mk(0, 4'b0000, 0, 3'd0, 8'h00, 1, 1, 0, 0, 8'h00, 4'b1001, 3, 4));
    vecs.push_back(mk(0, 4'b0000, 1, 3'd6, 8'h25, 0, 0, 1, 1, 8'h25, 4'b1001, 3, 4));
    vecs.push_back(mk(0, 4'b0000, 0, 3'd0, 8'h00, 1, 1, 0, 0, 8'h00, 4'b1001, 4, 4));

    repeat (2) step();
    checkCore("reset", 1'b1, 1'b0, 4'b0000, 16'd0, 16'd0);
    checkRes("reset", 1'b0, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].we, vecs[i].fin, vecs[i].pend, vecs[i].fl,
                    vecs[i].bv, vecs[i].cond, vecs[i].tgt, vecs[i].rr);
      step();
      checkCore($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_valid,
                vecs[i].e_flags, vecs[i].e_tcnt, vecs[i].e_ncnt);
      if (vecs[i].e_valid) checkRes($sformatf("vec%0d", i), vecs[i].e_taken, vecs[i].e_target);
    end

    // Pending flag write: LT waits three cycles for flags 1000
    applyStimulus(0, 4'b0000, 1, 0, 1, 3'd2, 8'h40, 0);
    step();
    checkCore("pend0", 1'b0, 1'b0, 4'b1001, 16'd4, 16'd4);
    applyStimulus(0, 4'b0000, 1, 0, 0, 3'd0, 8'h00, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      checkCore($sformatf("pend_wait%0d", i), 1'b0, 1'b0, 4'b1001, 16'd4, 16'd4);
    end
    applyStimulus(1, 4'b1000, 0, 0, 0, 3'd0, 8'h00, 0);
    step();
    checkCore("pend_res", 1'b0, 1'b1, 4'b1000, 16'd4, 16'd4);
    checkRes("pend_res", 1'b1, 8'h40);
    applyStimulus(0, 4'b0000, 0, 0, 0, 3'd0, 8'h00, 1);
    step();
    checkCore("pend_done", 1'b1, 1'b0, 4'b1000, 16'd5, 16'd4);

    // Backpressure: GE (not taken) held while decode keeps offering AL
    applyStimulus(0, 4'b0000, 0, 0, 1, 3'd3, 8'h55, 0);
    step();
    checkCore("bp_acc", 1'b0, 1'b1, 4'b1000, 16'd5, 16'd4);
    checkRes("bp_acc", 1'b0, 8'h55);
    applyStimulus(0, 4'b0000, 0, 0, 1, 3'd6, 8'h66, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      checkCore($sformatf("bp_hold%0d", i), 1'b0, 1'b1, 4'b1000, 16'd5, 16'd4);
      checkRes($sformatf("bp_hold%0d", i), 1'b0, 8'h55);
    end
    applyStimulus(0, 4'b0000, 0, 0, 1, 3'd6, 8'h66, 1);
    step();
    checkCore("bp_rel", 1'b1, 1'b0, 4'b1000, 16'd5, 16'd5);
    applyStimulus(0, 4'b0000, 0, 0, 1, 3'd6, 8'h66, 0);
    step();
    checkCore("bp_next", 1'b0, 1'b1, 4'b1000, 16'd5, 16'd5);
    checkRes("bp_next", 1'b1, 8'h66);
    applyStimulus(0, 4'b0000, 0, 0, 0, 3'd0, 8'h00, 1);
    step();
    checkCore("bp_next_rel", 1'b1, 1'b0, 4'b1000, 16'd6, 16'd5);

    // Flush in WAIT drops the branch
    applyStimulus(0, 4'b0000, 1, 0, 1, 3'd0, 8'h70, 0);
    step();
    checkCore("fw_wait", 1'b0, 1'b0, 4'b1000, 16'd6, 16'd5);
    applyStimulus(0, 4'b0000, 1, 1, 0, 3'd0, 8'h00, 0);
    step();
    checkCore("fw_flush", 1'b1, 1'b0, 4'b1000, 16'd6, 16'd5);
    applyStimulus(1, 4'b1000, 0, 0, 0, 3'd0, 8'h00, 0);
    step();
    checkCore("fw_after", 1'b1, 1'b0, 4'b1000, 16'd6, 16'd5);

    // Flush together with a RESP handshake and a concurrent flag write
    applyStimulus(0, 4'b0000, 0, 0, 1, 3'd6, 8'h71, 0);
    step();
    checkCore("fr_acc", 1'b0, 1'b1, 4'b1000, 16'd6, 16'd5);
    applyStimulus(1, 4'b0011, 0, 1, 1, 3'd6, 8'h72, 1);
    step();
    checkCore("fr_flush", 1'b1, 1'b0, 4'b0011, 16'd6, 16'd5);
    idleInputs();
    step();
    checkCore("fr_after", 1'b1, 1'b0, 4'b0011, 16'd6, 16'd5);

    // Flush in IDLE blocks capture of a simultaneous request
    applyStimulus(0, 4'b0000, 0, 1, 1, 3'd6, 8'h73, 0);
    step();
    checkCore("fi_flush", 1'b1, 1'b0, 4'b0011, 16'd6, 16'd5);
    idleInputs();
    step();
    checkCore("fi_after", 1'b1, 1'b0, 4'b0011, 16'd6, 16'd5);

    // Asynchronous reset in the middle of a resolution
    applyStimulus(0, 4'b0000, 0, 0, 1, 3'd6, 8'h7E, 0);
    step();
    checkCore("rst_pre", 1'b0, 1'b1, 4'b0011, 16'd6, 16'd5);
    idleInputs();
    rst_n = 1'b0;
    #1;
    checkCore("rst_mid", 1'b1, 1'b0, 4'b0000, 16'd0, 16'd0);
    checkRes("rst_mid", 1'b0, 8'h00);
    step();
    rst_n = 1'b1;
    step();
    checkCore("rst_post", 1'b1, 1'b0, 4'b0000, 16'd0, 16'd0);

    // Saturation on the 4-bit counter instance: 17 AL branches
    for (int i = 0; i < 17; i++) begin
      applyStimulus(0, 4'b0000, 0, 0, 1, 3'd6, 8'h01, 0);
      step();
      applyStimulus(0, 4'b0000, 0, 0, 0, 3'd0, 8'h00, 1);
      step();
    end
    idleInputs();
    step();
    checkOutput("sat.small_taken_cnt", 32'(s_taken_cnt), 32'd15);
    checkOutput("sat.small_not_taken_cnt", 32'(s_not_taken_cnt), 32'd0);
    checkOutput("sat.small_res_valid", 32'(s_res_valid), 32'd0);
    checkOutput("sat.small_br_ready", 32'(s_br_ready), 32'd1);
    checkOutput("sat.wide_taken_cnt", 32'(taken_cnt), 32'd17);
    checkOutput("sat.wide_not_taken_cnt", 32'(not_taken_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_condition_unit.md
# branch_condition_unit

Sequential consumer of the ALU status flags. Latches N/Z/C/V from the datapath's flag-producing logic, including the zero flag, into a flag register. Accepts branch requests from decode over a valid/ready handshake and resolves them against the current or forwarded flags. If a flag-setting instruction is still in flight, the request waits for its flags. The taken/not-taken result and the target go to fetch over a second valid/ready handshake.

## Interface
- ADDR_W, 8, branch target width
- CNT_W, 16, width of the saturating statistics counters
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flag_we  in  1  write flags_in into the flag register this cycle
- flags_in  in  4  {N,Z,C,V}; Z=1 means the ALU result was zero
- flag_pending  in  1  a flag-setting instruction is issued but not yet written back
- flush  in  1  synchronous; drops any captured or pending branch
- br_valid  in  1  branch request valid
- br_ready  out  1  unit can accept a request
- br_cond  in  3  condition code (see Operation)
- br_target  in  ADDR_W  branch target
- res_valid  out  1  resolution valid
- res_ready  in  1  fetch accepts the resolution
- res_taken  out  1  1 = branch taken
- res_target  out  ADDR_W  captured target
- flags_q  out  4  flag register {N,Z,C,V}
- taken_cnt, not_taken_cnt  out  CNT_W each  saturating counts of delivered resolutions

## Operation
- Condition codes:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 LT: N^V
  - 3 GE: !(N^V)
  - 4 LTU: !C
  - 5 GEU: C
  - 6 AL: 1
  - 7 NV: 0
- Flag register: loads flags_in on every cycle with flag_we=1, in any state, including during flush.
- Effective flags: flags_in when flag_we=1 (forwarding), else flags_q.
- IDLE: br_ready=1. On br_valid, capture br_cond and br_target.
  - If flag_pending=1 and flag_we=0, go to WAIT.
  - Otherwise evaluate on the effective flags, register res_taken, and go to RESP.
- WAIT: br_ready=0. On flag_we=1, evaluate on flags_in and go to RESP.
- RESP: br_ready=0 and res_valid=1. res_taken and res_target stay stable until res_ready=1. On the handshake, go to IDLE and increment the matching counter.
- Counters saturate at all-ones and are cleared only by rst_n.
- flush=1, any state: next state is IDLE and res_valid=0 next cycle.
  - A request presented in the same cycle is not captured.
  - A res_valid&&res_ready handshake in the same cycle is discarded and no counter increments.
- br_ready is a function of state only. It never depends on br_valid or res_ready.

## Timing
- Reset values:
  - state IDLE, br_ready 1
  - flags_q 0, res_valid 0, res_taken 0, res_target 0
  - counters 0
- Latency without a pending flag write:
  - Request accepted at edge k gives res_valid=1 after edge k.
  - The result reflects flags_in if flag_we=1 in the accept cycle.
- Latency with a pending flag write:
  - Resolution is registered at the edge where flag_we=1, and res_valid rises after that edge.
  - WAIT has no timeout.
- Throughput: at most one request every 2 cycles. The next accept is possible the cycle after the RESP handshake.
- res_valid never drops without a handshake, except on flush or reset.
- Asserting rst_n mid-operation immediately forces all outputs to their reset values. Any in-flight branch is lost.

## Structure
- Shared package branch_pkg holds:
  - the cond_e enum (EQ..NV with the encodings above)
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - the state enum {IDLE, WAIT, RESP}
- Sub-module cond_eval: purely combinational, mapping (flags[3:0], cond) to taken. It is instantiated once, fed by the effective-flag mux.

## Test plan
- Reset, then flag_we with flags_in=0100, then BR EQ target 0x3C. Required: res_valid one cycle after accept, res_taken=1, res_target=0x3C, taken_cnt=1.
- Forwarding: flags_q=0000, and in the accept cycle flag_we=1 with flags_in=0100 and cond NE. Required: res_taken=0, and flags_q=0100 afterwards.
- Pending: flag_pending=1 at accept, flag_we arrives 3 cycles later with flags 1000 and cond LT. Required: br_ready=0 throughout WAIT, res_valid rises the cycle after flag_we, res_taken=1.
- Backpressure: res_ready held 0 for 5 cycles in RESP while br_valid=1. Required: res_taken and res_target stable, no new accept, exactly one counter increment on release.
- Flush in WAIT, then flush together with a RESP handshake. Required: both branches dropped, counters unchanged, state IDLE, flags_q still updated by a concurrent flag_we.
- Saturation: CNT_W forced small (4), 17 AL branches. Required: taken_cnt=15, not_taken_cnt=0.
